// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX FIFO write port between several byte-stream requesters.
// A grant is held for a whole packet, and it is forcibly released after MaxPktLen bytes.
module uart_tx_arbiter #(
   parameter int NumReq    = 4,
   parameter int MaxPktLen = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic [NumReq-1:0]     req_valid_i,
   input  logic [8*NumReq-1:0]   req_data_i,
   input  logic [NumReq-1:0]     req_last_i,
   output logic [NumReq-1:0]     req_ready_o,
   output logic                  tx_wvalid_o,
   output logic [7:0]            tx_wdata_o,
   input  logic                  tx_wready_i,
   output logic [NumReq-1:0]     grant_o,
   output logic                  busy_o,
   output logic                  len_err_o
);

   localparam int IdxW = $clog2(NumReq);

   typedef enum logic {IDLE, XFER} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] grant_q, ptr_q, sel_idx, next_ptr;
   logic [IdxW:0]   idx_w;
   logic            sel_found;
   logic [7:0]      beat_q;
   logic            len_err_q;
   logic            take_grant, accept, pkt_done, force_rel;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // First valid requester at or after the priority pointer, wrapping around.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      idx_w     = '0;
      for (int k = 0; k < NumReq; k++) begin
         idx_w = {1'b0, ptr_q} + (IdxW+1)'(k);
         if (idx_w >= (IdxW+1)'(NumReq)) idx_w = idx_w - (IdxW+1)'(NumReq);
         if (!sel_found && req_valid_i[idx_w[IdxW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = idx_w[IdxW-1:0];
         end
      end
   end

   assign next_ptr = (grant_q == IdxW'(NumReq-1)) ? '0 : grant_q + IdxW'(1);

   always_comb begin
      state_d     = state_q;
      req_ready_o = '0;
      tx_wvalid_o = 1'b0;
      tx_wdata_o  = '0;
      take_grant  = 1'b0;
      accept      = 1'b0;
      pkt_done    = 1'b0;
      force_rel   = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i && sel_found) begin
               take_grant = 1'b1;
               state_d    = XFER;
            end
         end
         XFER: begin
            tx_wvalid_o = req_valid_i[grant_q];
            for (int i = 0; i < NumReq; i++) begin
               if (grant_q == IdxW'(i)) tx_wdata_o = req_data_i[8*i +: 8];
            end
            req_ready_o[grant_q] = tx_wready_i;
            accept = req_valid_i[grant_q] & tx_wready_i;
            // A last flag on the MaxPktLen-th beat is a normal completion, not an error.
            if (accept) begin
               if (req_last_i[grant_q])                   pkt_done  = 1'b1;
               else if (beat_q == 8'(MaxPktLen-1))        force_rel = 1'b1;
            end
            if (pkt_done || force_rel) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_q   <= '0;
         ptr_q     <= '0;
         beat_q    <= '0;
         len_err_q <= 1'b0;
      end else begin
         len_err_q <= force_rel;
         if (take_grant) begin
            grant_q <= sel_idx;
            beat_q  <= '0;
         end else if (accept && beat_q != 8'(MaxPktLen)) begin
            beat_q <= beat_q + 8'd1;
         end
         if (pkt_done || force_rel) ptr_q <= next_ptr;
      end
   end

   always_comb begin
      grant_o = '0;
      if (state_q == XFER) grant_o[grant_q] = 1'b1;
   end

   assign busy_o    = (state_q == XFER);
   assign len_err_o = len_err_q;

endmodule
